// File: rtl/full_adder_4b_if.sv
// Operand/result bundle for the registered 4-bit ripple-carry adder.
interface full_adder_4b_if;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [4:0] Sum;
  logic [4:0] Cout;

  modport master (output A, B, Cin, input Sum, Cout);
  modport slave  (input A, B, Cin, output Sum, Cout);
endinterface

// File: rtl/full_adder_4b.sv
// Two-stage registered 4-bit ripple-carry adder exposing its full carry chain.
module full_adder_4b (
  input  logic           clk,
  input  logic           rst,
  full_adder_4b_if.slave bus
);
  localparam int unsigned W = 4;

  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic         c_r;
  logic [W-1:0] s_c;
  logic [W:0]   carry_c;

  // Stage 1: capture operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      c_r <= 1'b0;
    end else begin
      a_r <= bus.A;
      b_r <= bus.B;
      c_r <= bus.Cin;
    end
  end

  // Ripple chain of 1-bit full-adder cells; a scalar carry walks the chain.
  always_comb begin
    logic c;
    s_c     = '0;
    carry_c = '0;
    c       = c_r;
    carry_c[0] = c;
    for (int i = 0; i < int'(W); i++) begin
      s_c[i]       = a_r[i] ^ b_r[i] ^ c;
      c            = (a_r[i] & b_r[i]) | (c & (a_r[i] ^ b_r[i]));
      carry_c[i+1] = c;
    end
  end

  // Stage 2: register result and carry vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.Sum  <= '0;
      bus.Cout <= '0;
    end else begin
      bus.Sum  <= {carry_c[W], s_c};
      bus.Cout <= carry_c;
    end
  end
endmodule

// File: tb/tb_full_adder_4b.sv
// Self-checking bench for full_adder_4b: directed table, pipelining, sweep with reset, random.
module tb_full_adder_4b;
  logic clk;
  logic rst;
  full_adder_4b_if bus ();

  full_adder_4b dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [4:0] sum;
    logic [4:0] cout;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: what stage 1 currently holds, and the expected outputs.
  logic [3:0] st_a, st_b;
  logic       st_c;
  logic [4:0] exp_sum, exp_cout;
  bit         known = 0;

  // Reference: arithmetic sum; carry into bit i = (low i bits of A + B + Cin) >> i.
  function automatic logic [9:0] ref_add(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int ai, bi, ci, m;
    logic [4:0] s, co;
    ai = int'(a); bi = int'(b); ci = int'(cin);
    s = 5'(ai + bi + ci);
    for (int i = 0; i < 5; i++) begin
      m = 1 << i;
      co[i] = 1'(((ai % m) + (bi % m) + ci) >> i);
    end
    return {s, co};
  endfunction

  task automatic check(input string name, input logic [4:0] act_s, input logic [4:0] act_c,
                       input logic [4:0] req_s, input logic [4:0] req_c);
    n_vec++;
    if (act_s !== req_s || act_c !== req_c) begin
      n_bad++;
      $display("FAIL %s: Sum=%b Cout=%b, required Sum=%b Cout=%b", name, act_s, act_c, req_s, req_c);
    end
  endtask

  // One clock edge: advance the model, then compare against it.
  task automatic tick(input string name);
    logic [9:0] r;
    logic [3:0] a, b;
    logic c, rs;
    a = bus.A; b = bus.B; c = bus.Cin; rs = rst;
    @(posedge clk);
    #1;
    if (rs) begin
      exp_sum = '0; exp_cout = '0;
      st_a = '0; st_b = '0; st_c = 1'b0;
      known = 1;
    end else begin
      r = ref_add(st_a, st_b, st_c);
      exp_sum = r[9:5]; exp_cout = r[4:0];
      st_a = a; st_b = b; st_c = c;
    end
    if (known) check(name, bus.Sum, bus.Cout, exp_sum, exp_cout);
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic cin);
    bus.A = a; bus.B = b; bus.Cin = cin;
  endtask

  vec_t tbl [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{4'b1101, 4'b0101, 1'b0, 5'b10010, 5'b11010};
    tbl[1] = '{4'b1010, 4'b0110, 1'b1, 5'b10001, 5'b11101};
    tbl[2] = '{4'b1111, 4'b1111, 1'b1, 5'b11111, 5'b11111};
    tbl[3] = '{4'b0000, 4'b0000, 1'b0, 5'b00000, 5'b00000};

    // Reset with all-ones inputs: outputs stay zero through reset and one edge after.
    rst = 1'b1;
    drive(4'hF, 4'hF, 1'b1);
    tick("reset_e1");
    check("reset_e1_zero", bus.Sum, bus.Cout, 5'b00000, 5'b00000);
    tick("reset_e2");
    check("reset_e2_zero", bus.Sum, bus.Cout, 5'b00000, 5'b00000);
    rst = 1'b0;
    tick("post_reset_e1");
    check("post_reset_e1_zero", bus.Sum, bus.Cout, 5'b00000, 5'b00000);
    tick("post_reset_e2");
    check("post_reset_e2_ones", bus.Sum, bus.Cout, 5'b11111, 5'b11111);

    // Directed table, each vector held for two edges.
    foreach (tbl[i]) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].cin);
      tick("table_e1");
      tick("table_e2");
      check($sformatf("table[%0d]", i), bus.Sum, bus.Cout, tbl[i].sum, tbl[i].cout);
    end

    // Back-to-back pipelining, starting from a nonzero output.
    drive(4'hF, 4'hF, 1'b1);
    tick("pipe_pre1");
    tick("pipe_pre2");
    drive(4'b0000, 4'b0000, 1'b0);
    tick("pipe_s0");
    drive(4'b1111, 4'b0000, 1'b1);
    tick("pipe_o0");
    check("pipe_out0", bus.Sum, bus.Cout, 5'b00000, 5'b00000);
    drive(4'b0001, 4'b0001, 1'b0);
    tick("pipe_o1");
    check("pipe_out1", bus.Sum, bus.Cout, 5'b10000, 5'b11111);
    tick("pipe_o2");
    check("pipe_out2", bus.Sum, bus.Cout, 5'b00010, 5'b00010);

    // Exhaustive sweep, one combination per edge, with a reset pulse midway.
    for (int i = 0; i < 512; i++) begin
      drive(4'(i >> 5), 4'(i >> 1), 1'(i));
      if (i == 300) begin
        rst = 1'b1;
        tick("sweep_rst");
        check("sweep_rst_zero", bus.Sum, bus.Cout, 5'b00000, 5'b00000);
        rst = 1'b0;
        tick("sweep_rst_after");
        check("sweep_rst_after_zero", bus.Sum, bus.Cout, 5'b00000, 5'b00000);
      end else begin
        tick("sweep");
      end
    end

    // Random vectors.
    for (int i = 0; i < 300; i++) begin
      drive(4'($urandom), 4'($urandom), 1'($urandom));
      tick("random");
    end
    tick("drain1");
    tick("drain2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/full_adder_4b.md
# full_adder_4b

Registered 4-bit ripple-carry adder. Two 4-bit operands and a carry-in are captured on the clock, added through a chain of four 1-bit full-adder cells, and presented as registered outputs:
- a 5-bit sum;
- a 5-bit carry-chain vector.

It is a small arithmetic leaf used as a pipelined datapath element. The carry vector is exposed for debug and for carry-select composition.

## Interface
Parameters: none (width fixed at 4).
- clk  input  1  Clock. Single clock domain; all state updates on the rising edge.
- rst  input  1  Reset. Synchronous, active-high.
- A  input  4  Operand A, unsigned.
- B  input  4  Operand B, unsigned.
- Cin  input  1  Carry into bit 0.
- Sum  output  5  Registered result A+B+Cin. Sum[4] is the final carry-out.
- Cout  output  5  Registered carry-chain vector {c4,c3,c2,c1,c0}:
  - c0 = Cin;
  - c(i+1) = carry out of bit cell i;
  - Cout[4] = Sum[4].

## Operation
- Stage 1 (input register): A, B and Cin are captured into aR, bR and cR on each rising clk edge.
- Combinational core: four chained 1-bit full-adder cells operate on aR, bR and cR.
  - s_i = a_i ^ b_i ^ c_i
  - c(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i))
  - c0 = cR
- Stage 2 (output register): Sum <= {c4,s3,s2,s1,s0} and Cout <= {c4,c3,c2,c1,c0} on each rising clk edge.
- Arithmetic is unsigned modulo nothing: the 5-bit Sum holds the full range 0..31, so overflow cannot occur.
- There are no enables or valid handshake. Every edge accepts new inputs and shifts the pipeline.

## Timing
- Latency is 2 clock edges:
  - inputs sampled at edge k appear on Sum/Cout after edge k+1;
  - outputs then hold until edge k+2 updates them with the next sample.
- Throughput: one result per cycle; back-to-back changes are pipelined independently.
- There is no combinational path from A, B or Cin to Sum or Cout. Outputs change only after rising clk.
- Reset:
  - at any edge where rst=1, all registers (aR, bR, cR, Sum, Cout) load 0;
  - Sum=5'b00000 and Cout=5'b00000 from that edge on.
- Reset mid-operation: samples in flight are discarded, and inputs presented while rst=1 are not captured.
- After rst deasserts, the inputs sampled at the first edge with rst=0 (edge j) produce output after edge j+1. Outputs read 0 until then.
- Inputs are held constant during a test step. X on inputs propagates to outputs 2 edges later; no special handling is required.

## Test plan
- Reset: assert rst for 2 edges with A=4'hF, B=4'hF, Cin=1 -> Sum=00000 and Cout=00000 throughout, and for 1 edge after deassert. The 2nd edge after deassert gives Sum=11111, Cout=11111.
- A=1101, B=0101, Cin=0, held ≥2 edges -> Sum=10010 and Cout=11010.
- A=1010, B=0110, Cin=1 -> Sum=10001 and Cout=11101.
- A=1111, B=1111, Cin=1 -> Sum=11111 and Cout=11111. A=0000, B=0000, Cin=0 -> Sum=00000 and Cout=00000.
- Latency/pipelining: change inputs every cycle (0+0+0, then 1111+0000+1, then 0001+0001+0) -> outputs 00000/00000, then 10000/11111, then 00010/00010 on consecutive cycles, each exactly 2 edges after its sample.
- Exhaustive sweep of all 512 input combinations, one per cycle -> Sum == A+B+Cin at 2-edge offset; Cout[4]==Sum[4]; Cout[0]==sampled Cin. A mid-sweep rst pulse zeroes the outputs and restarts the 2-edge latency.
